jtcps2_eeprom_93c46: RTL

Serial EEPROM responder: the device end of the CPS2 3-wire EEPROM link (SCS/SCLK/SDI in, SDO out) driven by the main CPU's I/O latch. It models a 93C46 in x16 organisation: 64 words, 6-bit address, full command set, write-enable latch and ready/busy status. A second port gives the frame host load/dump access for NVRAM persistence.

---
 rtl/jtcps2_eeprom_pkg.sv | 33 +++
 rtl/jtcps2_eeprom_if.sv | 26 ++
 rtl/jtcps2_eeprom_mem.sv | 34 +++
 rtl/jtcps2_eeprom_93c46.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jtcps2_eeprom_pkg.sv
// Shared definitions for the CPS2 93C46 serial EEPROM responder.
// Holds the serial opcode/subcode constants, the command FSM states and
// the kinds of program operation that can be armed for the BUSY phase.
package jtcps2_eeprom_pkg;

  // Two opcode bits that follow the start bit.
  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  // Extended commands are selected by addr[5:4] when the opcode is OP_EXT.
  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_WRAL = 2'b01;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_EWEN = 2'b11;

  localparam logic [15:0] WORD_ERASED = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, CMD, RD, WR, DONE, BUSY} state_t;

  // Program operation waiting for the chip-select fall.
  typedef enum logic [1:0] {ARM_WRITE, ARM_ERASE, ARM_WRAL, ARM_ERAL} arm_t;

  function automatic logic arm_is_all(input arm_t k);
    return (k == ARM_WRAL) || (k == ARM_ERAL);
  endfunction

  function automatic logic arm_is_erase(input arm_t k);
    return (k == ARM_ERASE) || (k == ARM_ERAL);
  endfunction

endpackage

// File: rtl/jtcps2_eeprom_if.sv
// Bundle of the EEPROM device-side signals.
//   scs/sclk/sdi/sdo : 3-wire serial link from the CPU I/O latch
//   dump_*           : host load/dump port used for NVRAM persistence
// master = CPU latch plus frame host, slave = the EEPROM model.
interface jtcps2_eeprom_if;
  logic        scs;
  logic        sclk;
  logic        sdi;
  logic        sdo;
  logic [5:0]  dump_addr;
  logic [15:0] dump_din;
  logic        dump_we;
  logic [15:0] dump_dout;
  logic        dump_clr;
  logic        dump_flag;

  modport master (
    output scs, sclk, sdi, dump_addr, dump_din, dump_we, dump_clr,
    input  sdo, dump_dout, dump_flag
  );

  modport slave (
    input  scs, sclk, sdi, dump_addr, dump_din, dump_we, dump_clr,
    output sdo, dump_dout, dump_flag
  );
endinterface

// File: rtl/jtcps2_eeprom_mem.sv
// 64x16 dual-port storage array with registered reads on both ports.
//   clk, rst_n          : clock, async active-low reset (host read register only)
//   a_addr_i/a_din_i/a_we_i/a_dout_o : serial-FSM port
//   b_addr_i/b_din_i/b_we_i/b_dout_o : host port, 1-cycle read latency
// When both ports write the same word in one cycle, port B (host) wins.
module jtcps2_eeprom_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  a_addr_i,
  input  logic [15:0] a_din_i,
  input  logic        a_we_i,
  output logic [15:0] a_dout_o,
  input  logic [5:0]  b_addr_i,
  input  logic [15:0] b_din_i,
  input  logic        b_we_i,
  output logic [15:0] b_dout_o
);

  logic [15:0] mem_q [64];

  // NOTE: the array has no reset so it maps onto block RAM and keeps its
  // contents across rst_n, which is what NVRAM persistence needs.
  always_ff @(posedge clk) begin
    if (a_we_i) mem_q[a_addr_i] <= a_din_i;
    if (b_we_i) mem_q[b_addr_i] <= b_din_i;
    a_dout_o <= mem_q[a_addr_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_dout_o <= '0;
    else        b_dout_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/jtcps2_eeprom_93c46.sv
// 93C46 (x16) serial EEPROM responder for the CPS2 3-wire link.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of jtcps2_eeprom_if (serial link + host dump port)
// Parameters: PROG_CYCLES = clk cycles a program/erase stays busy (>= 64),
//             INIT_WE     = power-up value of the write-enable latch.
module jtcps2_eeprom_93c46
  import jtcps2_eeprom_pkg::*;
#(
  parameter int PROG_CYCLES = 2048,
  parameter bit INIT_WE     = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  jtcps2_eeprom_if.slave bus
);

  localparam int             CW        = $clog2(PROG_CYCLES);
  localparam logic [CW-1:0]  BUSY_LAST = CW'(PROG_CYCLES - 1);

  logic [1:0]    scs_sync_q, sclk_sync_q, sdi_sync_q;
  logic          sclk_prev_q;
  logic          scs_s, sdi_s, sclk_rise;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [5:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          we_q, we_d;
  logic          armed_q, armed_d;
  arm_t          arm_q, arm_d;
  logic [6:0]    idx_q, idx_d;       // bit 6 set = all commits of this op done
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic          sdo_q, sdo_d;
  logic          flag_q, flag_d;

  logic [7:0]    cmd_full;
  logic          commit_pend;
  logic [5:0]    mem_a_addr;
  logic [15:0]   mem_a_din, mem_a_dout;
  logic          mem_a_we;

  assign scs_s     = scs_sync_q[1];
  assign sdi_s     = sdi_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign cmd_full  = {cmd_q[6:0], sdi_s};

  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    armed_d    = armed_q;
    arm_d      = arm_q;
    idx_d      = idx_q;
    busy_cnt_d = busy_cnt_q;
    sdo_d      = sdo_q;
    flag_d     = flag_q & ~bus.dump_clr;
    mem_a_addr = addr_q;
    mem_a_din  = data_q;
    mem_a_we   = 1'b0;
    commit_pend = (state_q == BUSY) && !idx_q[6];

    if (state_q == BUSY) begin
      // Serial link is ignored while programming; sdo reports busy.
      sdo_d = ~scs_s;
      if (commit_pend) begin
        if (arm_is_all(arm_q))   mem_a_addr = idx_q[5:0];
        if (arm_is_erase(arm_q)) mem_a_din  = WORD_ERASED;
        // A host write in the same cycle takes the RAM; retry next cycle.
        if (!bus.dump_we) begin
          mem_a_we = 1'b1;
          flag_d   = 1'b1;
          idx_d    = arm_is_all(arm_q) ? 7'(idx_q + 7'd1) : 7'd64;
        end
      end
      // A deferred commit stretches BUSY by the cycle it lost.
      if (!(commit_pend && bus.dump_we)) begin
        if (busy_cnt_q == BUSY_LAST) begin
          state_d    = IDLE;
          sdo_d      = 1'b1;
          busy_cnt_d = '0;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
    end else if (!scs_s) begin
      state_d    = armed_q ? BUSY : IDLE;
      cnt_d      = '0;
      sdo_d      = 1'b1;
      armed_d    = 1'b0;
      idx_d      = '0;
      busy_cnt_d = '0;
    end else if (sclk_rise) begin
      case (state_q)
        IDLE: if (sdi_s) begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: begin
          cmd_d = cmd_full;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d  = '0;
            addr_d = cmd_full[5:0];
            case (cmd_full[7:6])
              OP_READ: begin
                state_d = RD;
                sdo_d   = 1'b0;   // dummy bit ahead of the data
              end
              OP_WRITE: state_d = WR;
              OP_ERASE: begin
                armed_d = we_q;
                arm_d   = ARM_ERASE;
                state_d = DONE;
              end
              default: begin
                state_d = DONE;
                case (cmd_full[5:4])
                  EXT_EWEN: we_d = 1'b1;
                  EXT_EWDS: we_d = 1'b0;
                  EXT_ERAL: begin
                    armed_d = we_q;
                    arm_d   = ARM_ERAL;
                  end
                  default: state_d = WR;
                endcase
              end
            endcase
          end
        end
        RD: begin
          // Port A already holds mem[addr_q]: the next rise is >= 2 clk away.
          sdo_d = mem_a_dout[4'd15 - cnt_q];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) addr_d = addr_q + 6'd1;
        end
        WR: begin
          data_d = {data_q[14:0], sdi_s};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            armed_d = we_q;
            arm_d   = (cmd_q[7:6] == OP_WRITE) ? ARM_WRITE : ARM_WRAL;
            state_d = DONE;
          end
        end
        default: ;   // DONE waits for the chip-select fall
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scs_sync_q  <= '0;
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= INIT_WE;
      armed_q     <= 1'b0;
      arm_q       <= ARM_WRITE;
      idx_q       <= '0;
      busy_cnt_q  <= '0;
      sdo_q       <= 1'b1;
      flag_q      <= 1'b0;
    end else begin
      scs_sync_q  <= {scs_sync_q[0], bus.scs};
      sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
      sdi_sync_q  <= {sdi_sync_q[0], bus.sdi};
      sclk_prev_q <= sclk_sync_q[1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      armed_q     <= armed_d;
      arm_q       <= arm_d;
      idx_q       <= idx_d;
      busy_cnt_q  <= busy_cnt_d;
      sdo_q       <= sdo_d;
      flag_q      <= flag_d;
    end
  end

  assign bus.sdo       = sdo_q;
  assign bus.dump_flag = flag_q;

  jtcps2_eeprom_mem u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_addr_i (mem_a_addr),
    .a_din_i  (mem_a_din),
    .a_we_i   (mem_a_we),
    .a_dout_o (mem_a_dout),
    .b_addr_i (bus.dump_addr),
    .b_din_i  (bus.dump_din),
    .b_we_i   (bus.dump_we),
    .b_dout_o (bus.dump_dout)
  );

endmodule
